// File: rtl/myproject_mul_arb.sv
// Round-robin arbiter that time-shares one signed 13x16 multiplier and returns the low 24 bits of each product tagged with its requester index.
// Defining MYPROJECT_MUL_OREG_EN adds an output register stage, which raises latency from 2 to 3.
module myproject_mul_arb #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned ID_W = 2
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*13-1:0]   req_a,
  input  logic [NREQ*16-1:0]   req_b,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [ID_W-1:0]      res_id,
  output logic [23:0]          res_p,
  output logic                 idle
);

  logic                   stall;
  logic                   xfer;
  logic [ID_W-1:0]        ptr_q, ptr_d;
  logic [ID_W-1:0]        gnt_id;
  logic [12:0]            gnt_a;
  logic [15:0]            gnt_b;

  logic signed [12:0]     a1_q;
  logic signed [15:0]     b1_q;
  logic [ID_W-1:0]        id1_q;
  logic                   v1_q;

  logic [23:0]            p2_q;
  logic [ID_W-1:0]        id2_q;
  logic                   v2_q;
  logic [23:0]            prod_lo;

  assign stall = res_valid & ~res_ready;

  // Pass 1 takes the lowest valid index above ptr; pass 2 wraps around to the lowest valid index overall.
  always_comb begin
    logic found;
    req_ready = '0;
    gnt_id    = '0;
    found     = 1'b0;
    if (!ap_rst && !stall) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!found && req_valid[i] && (i > 32'(ptr_q))) begin
          found        = 1'b1;
          req_ready[i] = 1'b1;
          gnt_id       = ID_W'(i);
        end
      end
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!found && req_valid[i]) begin
          found        = 1'b1;
          req_ready[i] = 1'b1;
          gnt_id       = ID_W'(i);
        end
      end
    end
  end

  always_comb begin
    gnt_a = '0;
    gnt_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        gnt_a = req_a[13*i +: 13];
        gnt_b = req_b[16*i +: 16];
      end
    end
  end

  assign xfer  = |(req_valid & req_ready);
  assign ptr_d = xfer ? gnt_id : ptr_q;

  // The low 24 bits of the 29-bit product depend only on the low 24 bits of the sign-extended operands.
  assign prod_lo = 24'(a1_q) * 24'(b1_q);

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      ptr_q <= ID_W'(NREQ - 1);
      a1_q  <= '0;
      b1_q  <= '0;
      id1_q <= '0;
      v1_q  <= 1'b0;
      p2_q  <= '0;
      id2_q <= '0;
      v2_q  <= 1'b0;
    end else if (!stall) begin
      ptr_q <= ptr_d;
      v1_q  <= xfer;
      if (xfer) begin
        a1_q  <= gnt_a;
        b1_q  <= gnt_b;
        id1_q <= gnt_id;
      end
      p2_q  <= prod_lo;
      id2_q <= id1_q;
      v2_q  <= v1_q;
    end
  end

`ifdef MYPROJECT_MUL_OREG_EN
  logic [23:0]     p3_q;
  logic [ID_W-1:0] id3_q;
  logic            v3_q;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      p3_q  <= '0;
      id3_q <= '0;
      v3_q  <= 1'b0;
    end else if (!stall) begin
      p3_q  <= p2_q;
      id3_q <= id2_q;
      v3_q  <= v2_q;
    end
  end

  assign res_valid = v3_q;
  assign res_p     = p3_q;
  assign res_id    = id3_q;
  assign idle      = ~v1_q & ~v2_q & ~v3_q;
`else
  assign res_valid = v2_q;
  assign res_p     = p2_q;
  assign res_id    = id2_q;
  assign idle      = ~v1_q & ~v2_q;
`endif

endmodule

// File: tb/tb_myproject_mul_arb.sv
// Self-checking bench for myproject_mul_arb: directed spec vectors plus randomized traffic against a slot-based reference model.
module tb_myproject_mul_arb;
  localparam int N   = 4;
  localparam int IDW = 2;
`ifdef MYPROJECT_MUL_OREG_EN
  localparam int L = 3;
`else
  localparam int L = 2;
`endif

  logic              ap_clk = 1'b0;
  logic              ap_rst;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*13-1:0]   req_a;
  logic [N*16-1:0]   req_b;
  logic              res_valid;
  logic              res_ready;
  logic [IDW-1:0]    res_id;
  logic [23:0]       res_p;
  logic              idle;

  myproject_mul_arb #(.NREQ(N), .ID_W(IDW)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_id(res_id), .res_p(res_p), .idle(idle)
  );

  always #5 ap_clk = ~ap_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a latency-L delay line of result slots that advances whenever the output is not stalled.
  int          m_ptr = N - 1;
  bit          m_v[L];
  int          m_id[L];
  logic [23:0] m_p[L];

  function automatic bit m_stall();
    return m_v[L-1] && !res_ready;
  endfunction

  function automatic int m_grant();
    if (ap_rst || m_stall()) return -1;
    for (int k = 1; k <= N; k++) begin
      int i = (m_ptr + k) % N;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [23:0] m_prod(int i);
    logic signed [12:0] a;
    logic signed [15:0] b;
    int p;
    a = req_a[13*i +: 13];
    b = req_b[16*i +: 16];
    p = int'(a) * int'(b);
    return p[23:0];
  endfunction

  function automatic logic [N-1:0] onehot(int g);
    logic [N-1:0] r = '0;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  function automatic bit m_idle();
    for (int s = 0; s < L; s++) if (m_v[s]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic cyc();
    int g;
    g = m_grant();
    @(posedge ap_clk);
    if (ap_rst) begin
      m_ptr = N - 1;
      for (int s = 0; s < L; s++) begin m_v[s] = 1'b0; m_id[s] = 0; m_p[s] = '0; end
    end else if (!m_stall()) begin
      for (int s = L - 1; s > 0; s--) begin
        m_v[s] = m_v[s-1]; m_id[s] = m_id[s-1]; m_p[s] = m_p[s-1];
      end
      m_v[0] = (g >= 0);
      if (g >= 0) begin m_id[0] = g; m_p[0] = m_prod(g); m_ptr = g; end
    end
    @(negedge ap_clk);
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      req_a[13*i +: 13] = 13'($urandom());
      req_b[16*i +: 16] = 16'($urandom());
    end
  endtask

  task automatic test_reset();
    ap_rst = 1'b1; req_valid = '1; res_ready = 1'b1; rand_ops();
    @(negedge ap_clk);
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++;
      if (req_ready !== '0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", req_ready); end
      cyc();
    end
    ap_rst = 1'b0; req_valid = '0;
    #1;
    n_checks++;
    if (res_valid !== 1'b0 || res_id !== '0 || res_p !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got v=%b id=%0d p=%h want 0/0/000000", res_valid, res_id, res_p);
    end
    n_checks++;
    if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b want 1", idle); end
  endtask

  task automatic test_truncation();
    logic [12:0] va[4] = '{13'h1FFD, 13'h0FFF, 13'h1000, 13'h1000};
    logic [15:0] vb[4] = '{16'd100, 16'h7FFF, 16'h8000, 16'h7FFF};
    logic [23:0] vp[4] = '{24'hFFFED4, 24'hFF7001, 24'h000000, 24'h001000};
    res_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      req_a = '0; req_b = '0;
      req_a[12:0] = va[v]; req_b[15:0] = vb[v];
      req_valid = 4'b0001;
      #1;
      n_checks++;
      if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL trunc_grant[%0d]: got %b want 0001", v, req_ready); end
      cyc();
      req_valid = '0;
      for (int d = 1; d <= L; d++) begin
        #1;
        n_checks++;
        if (res_valid !== (d == L)) begin
          n_fail++; $display("FAIL trunc_latency[%0d] d=%0d: res_valid got %b want %b", v, d, res_valid, d == L);
        end
        if (d == L) begin
          n_checks++;
          if (res_id !== 2'd0 || res_p !== vp[v]) begin
            n_fail++; $display("FAIL trunc_value[%0d]: got id=%0d p=%h want id=0 p=%h", v, res_id, res_p, vp[v]);
          end
        end
        cyc();
      end
    end
  endtask

  task automatic test_round_robin();
    ap_rst = 1'b1; req_valid = '0; res_ready = 1'b1;
    cyc();
    ap_rst = 1'b0;
    for (int k = 0; k < 8 + L; k++) begin
      req_valid = (k < 8) ? '1 : '0;
      rand_ops();
      #1;
      if (k < 8) begin
        n_checks++;
        if (req_ready !== onehot(k % N)) begin
          n_fail++; $display("FAIL rr_grant k=%0d: got %b want %b", k, req_ready, onehot(k % N));
        end
      end
      if (k >= L) begin
        n_checks++;
        if (res_valid !== 1'b1 || res_id !== IDW'((k - L) % N) || res_p !== m_p[L-1]) begin
          n_fail++; $display("FAIL rr_result k=%0d: got v=%b id=%0d p=%h want v=1 id=%0d p=%h",
                             k, res_valid, res_id, res_p, (k - L) % N, m_p[L-1]);
        end
      end
      cyc();
    end
  endtask

  task automatic test_sparse();
    ap_rst = 1'b1; req_valid = '0; res_ready = 1'b1;
    cyc();
    ap_rst = 1'b0;
    for (int k = 0; k < 7; k++) begin
      logic [N-1:0] want;
      req_valid = (k < 4) ? 4'b1010 : 4'b0010;
      want = (k < 4) ? ((k % 2 == 0) ? 4'b0010 : 4'b1000) : 4'b0010;
      rand_ops();
      #1;
      n_checks++;
      if (req_ready !== want) begin n_fail++; $display("FAIL sparse_grant k=%0d: got %b want %b", k, req_ready, want); end
      cyc();
    end
    req_valid = '0;
  endtask

  // Phases: 3 fills, 3 stalled cycles, 1 release with requests still pending, then drain.
  task automatic test_backpressure();
    for (int c = 0; c < 9 + L; c++) begin
      req_valid = (c < 7) ? '1 : '0;
      res_ready = !(c >= 3 && c < 6);
      rand_ops();
      #1;
      if (c >= 3 && c < 6) begin
        n_checks++;
        if (req_ready !== '0) begin n_fail++; $display("FAIL bp_ready_low c=%0d: got %b want 0", c, req_ready); end
      end
      n_checks++;
      if (req_ready !== onehot(m_grant())) begin
        n_fail++; $display("FAIL bp_grant c=%0d: got %b want %b", c, req_ready, onehot(m_grant()));
      end
      n_checks++;
      if (res_valid !== m_v[L-1]) begin n_fail++; $display("FAIL bp_valid c=%0d: got %b want %b", c, res_valid, m_v[L-1]); end
      if (m_v[L-1]) begin
        n_checks++;
        if (res_id !== IDW'(m_id[L-1]) || res_p !== m_p[L-1]) begin
          n_fail++; $display("FAIL bp_data c=%0d: got id=%0d p=%h want id=%0d p=%h", c, res_id, res_p, m_id[L-1], m_p[L-1]);
        end
      end
      cyc();
    end
    res_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    res_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      req_valid = onehot(c);
      rand_ops();
      cyc();
    end
    ap_rst = 1'b1; req_valid = '1;
    #1;
    n_checks++;
    if (req_ready !== '0) begin n_fail++; $display("FAIL rstmid_ready: got %b want 0", req_ready); end
    cyc();
    ap_rst = 1'b0; req_valid = '0;
    for (int c = 0; c < L + 2; c++) begin
      #1;
      n_checks++;
      if (res_valid !== 1'b0 || idle !== 1'b1) begin
        n_fail++; $display("FAIL rstmid_flush c=%0d: got v=%b idle=%b want v=0 idle=1", c, res_valid, idle);
      end
      cyc();
    end
    req_valid = '1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rstmid_first_grant: got %b want 0001", req_ready); end
    cyc();
    req_valid = '0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      ap_rst    = ($urandom_range(0, 63) == 0);
      req_valid = N'($urandom());
      res_ready = ($urandom_range(0, 3) != 0);
      rand_ops();
      #1;
      n_checks++;
      if (req_ready !== onehot(m_grant())) begin
        n_fail++; $display("FAIL rand_grant c=%0d: got %b want %b", c, req_ready, onehot(m_grant()));
      end
      n_checks++;
      if (res_valid !== m_v[L-1]) begin n_fail++; $display("FAIL rand_valid c=%0d: got %b want %b", c, res_valid, m_v[L-1]); end
      if (m_v[L-1]) begin
        n_checks++;
        if (res_id !== IDW'(m_id[L-1]) || res_p !== m_p[L-1]) begin
          n_fail++; $display("FAIL rand_data c=%0d: got id=%0d p=%h want id=%0d p=%h", c, res_id, res_p, m_id[L-1], m_p[L-1]);
        end
      end
      n_checks++;
      if (idle !== m_idle()) begin n_fail++; $display("FAIL rand_idle c=%0d: got %b want %b", c, idle, m_idle()); end
      cyc();
    end
    ap_rst = 1'b0; req_valid = '0; res_ready = 1'b1;
  endtask

  initial begin
    ap_rst = 1'b1; req_valid = '0; res_ready = 1'b1; req_a = '0; req_b = '0;
    test_reset();
    test_truncation();
    test_round_robin();
    test_sparse();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
